// File: rtl/cnf_loader_pkg.sv
// Shared constants and types for the CNF clause loader and the solver's clause memory.
package cnf_loader_pkg;

  localparam int unsigned NumVarsDef    = 64;
  localparam int unsigned NumClausesDef = 256;
  localparam int unsigned MaxLitsDef    = 3;
  localparam int unsigned VarWDef       = $clog2(NumVarsDef + 1);

  // One literal slot of a clause word; an all-zero slot is unused.
  typedef struct packed {
    logic               used;
    logic               neg;
    logic [VarWDef-1:0] var_idx;
  } lit_slot_t;

  typedef enum logic [2:0] {
    ErrNone         = 3'd0,
    ErrVarRange     = 3'd1,
    ErrTooManyLits  = 3'd2,
    ErrMemFull      = 3'd3,
    ErrEmptyClause  = 3'd4,
    ErrEofMidClause = 3'd5
  } err_code_e;

  typedef enum logic [2:0] {
    StIdle,
    StCollect,
    StWrite,
    StDone,
    StError
  } load_state_e;

endpackage

// File: rtl/cnf_loader.sv
// Packs a DIMACS-style literal stream into clause words, writes them to the clause
// memory, and pulses start to the solver once a well-formed formula has been loaded.
module cnf_loader
  import cnf_loader_pkg::*;
#(
  parameter int unsigned NUM_VARS    = NumVarsDef,
  parameter int unsigned NUM_CLAUSES = NumClausesDef,
  parameter int unsigned MAX_LITS    = MaxLitsDef,
  parameter int unsigned VAR_W       = $clog2(NUM_VARS + 1),
  parameter int unsigned CL_W        = $clog2(NUM_CLAUSES)
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            load_begin,
  input  logic                            lit_valid,
  output logic                            lit_ready,
  input  logic [VAR_W-1:0]                lit_var,
  input  logic                            lit_neg,
  input  logic                            lit_eof,
  output logic                            cl_we,
  output logic [CL_W-1:0]                 cl_addr,
  output logic [MAX_LITS*(2+VAR_W)-1:0]   cl_data,
  output logic [CL_W:0]                   num_clauses,
  output logic                            start,
  output logic                            busy,
  output logic                            error,
  output logic [2:0]                      err_code
);

  localparam int unsigned SlotW = 2 + VAR_W;
  localparam int unsigned DataW = MAX_LITS * SlotW;
  localparam int unsigned CntW  = $clog2(MAX_LITS + 1);

  localparam logic [VAR_W-1:0] MaxVar    = VAR_W'(NUM_VARS);
  localparam logic [CL_W:0]    FullCount = (CL_W + 1)'(NUM_CLAUSES);
  localparam logic [CntW-1:0]  CntFull   = CntW'(MAX_LITS);

  load_state_e          state_q, state_d;
  logic [DataW-1:0]     buf_q, buf_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [CL_W:0]        num_q, num_d;
  err_code_e            err_q, err_d;
  logic                 start_q, start_d;

  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    cnt_d   = cnt_q;
    num_d   = num_q;
    err_d   = err_q;

    unique case (state_q)
      StIdle, StDone, StError: begin
        if (load_begin) begin
          buf_d   = '0;
          cnt_d   = '0;
          num_d   = '0;
          err_d   = ErrNone;
          state_d = StCollect;
        end
      end

      StCollect: begin
        if (lit_valid) begin
          if (lit_eof) begin
            if (cnt_q != '0) begin
              err_d   = ErrEofMidClause;
              state_d = StError;
            end else begin
              state_d = StDone;
            end
          end else if (lit_var == '0) begin
            if (cnt_q == '0) begin
              err_d   = ErrEmptyClause;
              state_d = StError;
            end else if (num_q == FullCount) begin
              err_d   = ErrMemFull;
              state_d = StError;
            end else begin
              state_d = StWrite;
            end
          end else if (lit_var > MaxVar) begin
            err_d   = ErrVarRange;
            state_d = StError;
          end else if (cnt_q == CntFull) begin
            err_d   = ErrTooManyLits;
            state_d = StError;
          end else begin
            for (int i = 0; i < int'(MAX_LITS); i++) begin
              if (cnt_q == i[CntW-1:0]) begin
                buf_d[i*SlotW +: SlotW] = {1'b1, lit_neg, lit_var};
              end
            end
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      StWrite: begin
        num_d   = num_q + 1'b1;
        buf_d   = '0;
        cnt_d   = '0;
        state_d = StCollect;
      end

      default: state_d = StIdle;
    endcase
  end

  // start fires only on the transition into DONE, so it stays a single-cycle pulse.
  assign start_d = (state_d == StDone) && (state_q != StDone);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      buf_q   <= '0;
      cnt_q   <= '0;
      num_q   <= '0;
      err_q   <= ErrNone;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      cnt_q   <= cnt_d;
      num_q   <= num_d;
      err_q   <= err_d;
      start_q <= start_d;
    end
  end

  assign lit_ready   = (state_q == StCollect);
  assign cl_we       = (state_q == StWrite);
  assign cl_addr     = num_q[CL_W-1:0];
  assign cl_data     = cl_we ? buf_q : '0;
  assign num_clauses = num_q;
  assign start       = start_q;
  assign busy        = (state_q == StCollect) || (state_q == StWrite);
  assign error       = (state_q == StError);
  assign err_code    = err_q;

endmodule

// File: tb/tb_cnf_loader.sv
// Randomized self-checking bench for cnf_loader against a clause-level reference model.
module tb_cnf_loader;

  localparam int NV = 64;
  localparam int NC = 4;
  localparam int ML = 3;
  localparam int VW = 7;
  localparam int CW = 2;
  localparam int SW = 2 + VW;
  localparam int DW = ML * SW;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          load_begin = 1'b0;
  logic          lit_valid = 1'b0;
  logic          lit_ready;
  logic [VW-1:0] lit_var = '0;
  logic          lit_neg = 1'b0;
  logic          lit_eof = 1'b0;
  logic          cl_we;
  logic [CW-1:0] cl_addr;
  logic [DW-1:0] cl_data;
  logic [CW:0]   num_clauses;
  logic          start;
  logic          busy;
  logic          error;
  logic [2:0]    err_code;

  cnf_loader #(
    .NUM_VARS    (NV),
    .NUM_CLAUSES (NC),
    .MAX_LITS    (ML)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .load_begin  (load_begin),
    .lit_valid   (lit_valid),
    .lit_ready   (lit_ready),
    .lit_var     (lit_var),
    .lit_neg     (lit_neg),
    .lit_eof     (lit_eof),
    .cl_we       (cl_we),
    .cl_addr     (cl_addr),
    .cl_data     (cl_data),
    .num_clauses (num_clauses),
    .start       (start),
    .busy        (busy),
    .error       (error),
    .err_code    (err_code)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    int v;
    bit n;
    bit e;
  } beat_t;

  typedef struct {
    int            addr;
    logic [DW-1:0] data;
    int            c;
    logic          rdy;
  } wr_t;

  beat_t stim[$];
  wr_t   got_w[$];
  int    start_cnt;
  int    start_cyc;
  int    n_checks = 0;
  int    n_fail   = 0;

  always @(negedge clock) begin
    if (!reset) begin
      if (cl_we) got_w.push_back('{int'(cl_addr), cl_data, cyc, lit_ready});
      if (start) begin
        start_cnt++;
        start_cyc = cyc;
      end
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] pack(input beat_t l[$]);
    logic [DW-1:0] d = '0;
    foreach (l[i]) d[i*SW +: SW] = {1'b1, l[i].n, VW'(l[i].v)};
    return d;
  endfunction

  task automatic add_lit(input int v, input bit n);
    stim.push_back('{v, n, 1'b0});
  endtask

  task automatic add_term();
    stim.push_back('{0, 1'($urandom_range(0, 1)), 1'b0});
  endtask

  task automatic add_eof();
    stim.push_back('{$urandom_range(0, NV), 1'($urandom_range(0, 1)), 1'b1});
  endtask

  task automatic check_reset_outputs(input string pfx);
    check_eq({pfx, "_ready"}, 64'(lit_ready), 0);
    check_eq({pfx, "_we"}, 64'(cl_we), 0);
    check_eq({pfx, "_start"}, 64'(start), 0);
    check_eq({pfx, "_busy"}, 64'(busy), 0);
    check_eq({pfx, "_error"}, 64'(error), 0);
    check_eq({pfx, "_errcode"}, 64'(err_code), 0);
    check_eq({pfx, "_numcl"}, 64'(num_clauses), 0);
    check_eq({pfx, "_addr"}, 64'(cl_addr), 0);
    check_eq({pfx, "_data"}, 64'(cl_data), 0);
  endtask

  // Reference model works per clause: a list of pending literals and a clause count.
  task automatic run_load(input string tag);
    beat_t         cur[$];
    logic [DW-1:0] exp_w[$];
    int            exp_widx[$];
    int            acc[$];
    int            exp_err = 0;
    bit            exp_done = 0;
    int            ncl = 0;
    int            nacc;
    bit            timed_out = 0;
    int            nw;

    nacc = stim.size();
    for (int i = 0; i < stim.size(); i++) begin
      if (stim[i].e) begin
        if (cur.size() != 0) exp_err = 5;
        else exp_done = 1;
        nacc = i + 1;
        break;
      end else if (stim[i].v == 0) begin
        if (cur.size() == 0) begin
          exp_err = 4; nacc = i + 1; break;
        end else if (ncl == NC) begin
          exp_err = 3; nacc = i + 1; break;
        end
        exp_w.push_back(pack(cur));
        exp_widx.push_back(i);
        ncl++;
        cur.delete();
      end else if (stim[i].v > NV) begin
        exp_err = 1; nacc = i + 1; break;
      end else if (cur.size() == ML) begin
        exp_err = 2; nacc = i + 1; break;
      end else begin
        cur.push_back(stim[i]);
      end
    end

    got_w.delete();
    start_cnt = 0;
    start_cyc = -1;
    @(negedge clock) load_begin = 1'b1;
    @(negedge clock) load_begin = 1'b0;
    for (int i = 0; i < nacc; i++) begin
      int w = 0;
      repeat ($urandom_range(0, 2)) begin
        lit_valid  = 1'b0;
        load_begin = ($urandom_range(0, 4) == 0);
        @(negedge clock);
      end
      lit_valid = 1'b1;
      lit_var   = VW'(stim[i].v);
      lit_neg   = stim[i].n;
      lit_eof   = stim[i].e;
      while (!lit_ready && w < 50) begin
        @(negedge clock);
        w++;
      end
      if (!lit_ready) begin
        check_eq({tag, "_ready_timeout"}, 0, 1);
        timed_out = 1;
        break;
      end
      acc.push_back(cyc);
      @(negedge clock);
    end
    lit_valid  = 1'b0;
    lit_eof    = 1'b0;
    load_begin = 1'b0;
    repeat (4) @(negedge clock);

    nw = (got_w.size() < exp_w.size()) ? got_w.size() : exp_w.size();
    check_eq({tag, "_nwrites"}, 64'(got_w.size()), 64'(exp_w.size()));
    for (int i = 0; i < nw; i++) begin
      check_eq({tag, "_waddr"}, 64'(got_w[i].addr), 64'(i));
      check_eq({tag, "_wdata"}, 64'(got_w[i].data), 64'(exp_w[i]));
      check_eq({tag, "_wready"}, 64'(got_w[i].rdy), 0);
      if (!timed_out) check_eq({tag, "_wcycle"}, 64'(got_w[i].c), 64'(acc[exp_widx[i]] + 1));
    end
    check_eq({tag, "_numcl"}, 64'(num_clauses), 64'(exp_w.size()));
    check_eq({tag, "_error"}, 64'(error), 64'(exp_err != 0));
    check_eq({tag, "_errcode"}, 64'(err_code), 64'(exp_err));
    check_eq({tag, "_nstart"}, 64'(start_cnt), 64'(exp_done));
    check_eq({tag, "_busy"}, 64'(busy), 64'(!(exp_done || exp_err != 0)));
    if (exp_done && !timed_out) check_eq({tag, "_startcyc"}, 64'(start_cyc), 64'(acc[nacc-1] + 1));
  endtask

  task automatic gen_clean();
    int ncl = $urandom_range(0, NC + 1);
    stim.delete();
    repeat (ncl) begin
      repeat ($urandom_range(1, ML)) add_lit($urandom_range(1, NV), 1'($urandom_range(0, 1)));
      add_term();
    end
    add_eof();
  endtask

  task automatic gen_noisy();
    stim.delete();
    repeat (24) begin
      int r = $urandom_range(0, 99);
      if (r < 4) add_lit($urandom_range(NV + 1, (1 << VW) - 1), 1'($urandom_range(0, 1)));
      else if (r < 62) add_lit($urandom_range(1, NV), 1'($urandom_range(0, 1)));
      else if (r < 90) add_term();
      else add_eof();
    end
    add_eof();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1);
  end

  initial begin
    #12;
    check_reset_outputs("rst");
    @(negedge clock) reset = 1'b0;

    // (1 | ~2), (3), eof
    stim.delete();
    add_lit(1, 0); add_lit(2, 1); add_term(); add_lit(3, 0); add_term(); add_eof();
    run_load("basic");
    if (got_w.size() == 2) begin
      check_eq("basic_word0", 64'(got_w[0].data), 64'h30501);
      check_eq("basic_word1", 64'(got_w[1].data), 64'h00103);
    end else begin
      check_eq("basic_wordcount", 64'(got_w.size()), 2);
    end

    stim.delete(); add_lit(4, 0); add_lit(65, 1); add_term(); add_eof();
    run_load("varrange");
    check_eq("varrange_code", 64'(err_code), 1);

    stim.delete(); add_lit(1, 0); add_lit(2, 0); add_lit(3, 1); add_lit(4, 0); add_term();
    run_load("toomany");
    check_eq("toomany_code", 64'(err_code), 2);

    stim.delete(); add_lit(64, 1); add_lit(10, 0); add_lit(7, 1); add_term(); add_eof();
    run_load("recover");

    stim.delete();
    for (int k = 0; k < 5; k++) begin add_lit(k + 1, k[0]); add_term(); end
    add_eof();
    run_load("memfull");
    check_eq("memfull_code", 64'(err_code), 3);

    stim.delete(); add_term(); run_load("emptycl");
    stim.delete(); add_lit(5, 0); add_lit(6, 1); add_eof(); run_load("eofmid");
    stim.delete(); add_eof(); run_load("eofonly");
    check_eq("eofonly_start", 64'(start_cnt), 1);

    for (int k = 0; k < 30; k++) begin
      if (k[0]) gen_noisy();
      else gen_clean();
      run_load($sformatf("rnd%0d", k));
    end

    // Asynchronous reset in the middle of a clause with a chattering valid line.
    @(negedge clock) load_begin = 1'b1;
    @(negedge clock) load_begin = 1'b0;
    lit_valid = 1'b1; lit_var = 7'd9; lit_neg = 1'b0; lit_eof = 1'b0;
    @(negedge clock);
    repeat (6) begin
      lit_valid = 1'($urandom_range(0, 1));
      lit_var   = VW'($urandom_range(1, NV));
      lit_neg   = 1'($urandom_range(0, 1));
      @(negedge clock);
    end
    #2 reset = 1'b1;
    #1 check_reset_outputs("midrst");
    lit_valid = 1'b0;
    @(negedge clock) reset = 1'b0;

    stim.delete(); add_lit(12, 1); add_term(); add_lit(33, 0); add_lit(40, 1); add_term(); add_eof();
    run_load("postrst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cnf_loader.md
# cnf_loader

Front-end loader for the SAT solver core. Accepts a DIMACS-style literal stream over a valid/ready handshake and packs each clause into one clause-memory word. Writes the words into the clause database and counts the clauses. After the end-of-formula marker it pulses `start` to the solver top, which then reports `sat`/`unsat`. It also detects malformed input and refuses to start the solver when it does.

## Interface
Parameters:
- NUM_VARS, 64, highest legal variable index; variables are 1..NUM_VARS
- NUM_CLAUSES, 256, clause-memory depth
- MAX_LITS, 3, literal slots per clause word
- VAR_W, $clog2(NUM_VARS+1), variable index width
- CL_W, $clog2(NUM_CLAUSES), clause address width

Ports:
- clock  in  1  system clock, all state on posedge
- reset  in  1  asynchronous, active-high; clears all state
- load_begin  in  1  pulse in IDLE/DONE/ERROR; starts a new formula load
- lit_valid  in  1  literal beat valid
- lit_ready  out  1  loader accepts beat
- lit_var  in  VAR_W  variable index; 0 = clause terminator
- lit_neg  in  1  literal negated (ignored on terminator)
- lit_eof  in  1  end of formula; beat carries no literal
- cl_we  out  1  clause-memory write strobe
- cl_addr  out  CL_W  clause index being written
- cl_data  out  MAX_LITS*(2+VAR_W)  packed slots {used, neg, var}; slot 0 in LSBs
- num_clauses  out  CL_W+1  clauses written so far
- start  out  1  one-cycle pulse to solver top
- busy  out  1  state is COLLECT or WRITE
- error  out  1  sticky until load_begin or reset
- err_code  out  3  0 none, 1 var range, 2 too many lits, 3 memory full, 4 empty clause, 5 eof mid-clause

## Operation
- States: IDLE, COLLECT, WRITE, DONE, ERROR.
- IDLE: `lit_ready`=0. On `load_begin`, clear the clause buffer, `num_clauses`, `error` and `err_code`, then go to COLLECT.
- COLLECT: `lit_ready`=1. Precedence per accepted beat is `lit_eof` > terminator > literal.
- Literal beat (var 1..NUM_VARS): store it in the next free slot and increment the slot count.
  - var > NUM_VARS → ERROR, code 1.
  - Slot count already MAX_LITS → ERROR, code 2.
- Terminator beat:
  - Slot count 0 → ERROR, code 4.
  - `num_clauses` == NUM_CLAUSES → ERROR, code 3.
  - Otherwise go to WRITE.
- Eof beat:
  - Slot count ≠ 0 → ERROR, code 5.
  - Otherwise go to DONE.
- WRITE: `lit_ready`=0 and `cl_we`=1 for exactly one cycle, with `cl_addr`=`num_clauses` and `cl_data`=buffer. Unused slots are all-zero.
  - At the end of the cycle: increment `num_clauses`, clear the buffer, return to COLLECT.
- DONE: `start`=1 in the first DONE cycle only, then hold. `num_clauses` holds its final value. `load_begin` returns to COLLECT.
- ERROR: `lit_ready`=0, no `start`, `error`=1. `load_begin` returns to COLLECT.
- Duplicate or complementary literals within a clause are not checked.
- A zero-clause formula (eof first) is legal: DONE with `num_clauses`=0.

## Timing
- Reset values:
  - State IDLE; `lit_ready`, `cl_we`, `start`, `busy`, `error` = 0.
  - `err_code`=0, `num_clauses`=0, `cl_addr`=0, `cl_data`=0.
- A beat is accepted only on a cycle with `lit_valid`&&`lit_ready`. `lit_ready` is a pure function of state.
- Terminator accepted at cycle t → `cl_we` high at t+1 → `lit_ready` high again at t+2. Throughput is one clause per (lits+2) cycles.
- Eof accepted at t → `start` high during t+1 only.
- Error-causing beat at t → `error`/`err_code` valid from t+1.
- `load_begin` asserted in COLLECT or WRITE is ignored.
- Asynchronous reset mid-load returns to IDLE immediately. A partial write never completes, and the clause memory keeps stale contents.

## Structure
- `sysdefs.svh` holds the shared constants and types:
  - NUM_VARS, NUM_CLAUSES, MAX_LITS.
  - The packed literal-slot typedef {used, neg, var}, shared with the solver's clause memory.
  - The err_code enum and the loader state enum.
- A single module is sufficient; no sub-module is needed.
- The clause memory is external, and `cl_*` connect to its write port.

## Test plan
- Load (1 ∨ ¬2), (3), eof → two writes:
  - addr 0 = {slot0 var1 pos, slot1 var2 neg, slot2 0}.
  - addr 1 = {var3 pos}.
  - `num_clauses`=2, `start` pulses once, 1 cycle after eof.
- Literal var=65 with NUM_VARS=64 → `error`=1, `err_code`=1, no `cl_we`, no `start`.
- Four literals before the terminator → `err_code`=2 on the 4th beat; recovery via `load_begin` then a valid load succeeds.
- NUM_CLAUSES=4 and five clauses → four writes, `err_code`=3 on the fifth terminator.
- Terminator first → `err_code`=4. Literals then eof → `err_code`=5. Eof alone → DONE, `num_clauses`=0, `start` pulses.
- Reset asserted asynchronously mid-clause while `lit_valid` toggles randomly → all outputs return to reset values; the next load produces correct words.
